// File: rtl/bch_pkg.sv
// bch_pkg: shared BCH decoder constants and Euclid controller state encoding.
package bch_pkg;
  localparam int T = 8;
  localparam int M = 13;
  localparam int NUM_CELLS = 4;
  localparam int DEG_W = 5;
  localparam int SEQ_LEN = 2 * T + 1;
  localparam int NUM_PASSES = 2 * T / NUM_CELLS;
  typedef enum logic [2:0] {IDLE, LOAD, ITER, HOLD, OUT} state_t;
endpackage

// File: rtl/euclid_pass_counter.sv
// euclid_pass_counter: loop cycle counter with wrap and saturating pass count.
module euclid_pass_counter #(
  parameter int LOOP_LEN = 20,
  parameter int NUM_PASSES = 4,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  output logic [CW-1:0] cyc_nxt,
  output logic [2:0]    pass_cnt,
  output logic [2:0]    pass_nxt,
  output logic          loop_end
);
  localparam logic [CW-1:0] LAST = CW'(LOOP_LEN - 1);
  localparam logic [2:0] PMAX = 3'(NUM_PASSES);
  logic [CW-1:0] cyc_cnt;
  always_comb begin
    loop_end = cyc_cnt == LAST;
    cyc_nxt = clr || loop_end ? '0 : cyc_cnt + 1'b1;
    pass_nxt = clr ? '0 : loop_end && pass_cnt != PMAX ? pass_cnt + 1'b1 : pass_cnt;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cyc_cnt <= '0;
      pass_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_nxt;
      pass_cnt <= pass_nxt;
    end
endmodule

// File: rtl/euclid_fold_ctrl.sv
// euclid_fold_ctrl: sequences load, recirculation and readout of the folded
// 4-cell Euclidean key-equation array; all outputs are registered.
module euclid_fold_ctrl
  import bch_pkg::*;
#(
  parameter int LOOP_LEN = 20,
  parameter int SEQ_LEN = bch_pkg::SEQ_LEN,
  parameter int NUM_PASSES = bch_pkg::NUM_PASSES,
  parameter int CW = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       syn_valid,
  output logic       syn_ready,
  output logic       src_en,
  output logic       arr_start,
  output logic       arr_feedback_sel,
  input  logic       arr_stop,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_fail,
  output logic       done,
  output logic       busy,
  output logic [2:0] pass_cnt
);
  localparam logic [CW-1:0] LAST = CW'(LOOP_LEN - 1);
  localparam logic [CW-1:0] SL = CW'(SEQ_LEN);
  localparam logic [2:0] PMAX = 3'(NUM_PASSES);
  state_t state, state_nxt;
  logic clr, loop_end, fail_nxt;
  logic [CW-1:0] cyc_nxt;
  logic [2:0] pass_nxt;
  assign clr = state == IDLE || (state == OUT && loop_end);
  euclid_pass_counter #(.LOOP_LEN(LOOP_LEN), .NUM_PASSES(NUM_PASSES), .CW(CW)) u_cnt (
    .clk(clk),
    .reset(reset),
    .clr(clr),
    .cyc_nxt(cyc_nxt),
    .pass_cnt(pass_cnt),
    .pass_nxt(pass_nxt),
    .loop_end(loop_end)
  );
  always_comb begin
    state_nxt = state;
    fail_nxt = out_fail;
    case (state)
      IDLE: if (syn_valid && syn_ready) begin
        state_nxt = LOAD;
        fail_nxt = 1'b0;
      end
      LOAD: if (loop_end) state_nxt = ITER;
      ITER: if (loop_end && pass_nxt == PMAX) begin
        state_nxt = out_ready ? OUT : HOLD;
        fail_nxt = ~arr_stop;
      end
      // stopped cells pass data through, so the loop can idle here indefinitely
      HOLD: if (loop_end) begin
        fail_nxt = ~arr_stop;
        state_nxt = out_ready ? OUT : HOLD;
      end
      OUT: if (loop_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      syn_ready <= 1'b1;
      arr_feedback_sel <= 1'b1;
      src_en <= 1'b0;
      arr_start <= 1'b0;
      out_valid <= 1'b0;
      out_fail <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_nxt;
      syn_ready <= state_nxt == IDLE;
      busy <= state_nxt != IDLE;
      arr_feedback_sel <= state_nxt == IDLE || state_nxt == LOAD;
      src_en <= state_nxt == LOAD && cyc_nxt < SL;
      arr_start <= state_nxt == LOAD && cyc_nxt == '0;
      out_valid <= state_nxt == OUT && cyc_nxt < SL;
      done <= state_nxt == OUT && cyc_nxt == LAST;
      out_fail <= fail_nxt;
    end
endmodule

// File: doc/euclid_fold_ctrl.md
Name: euclid_fold_ctrl

Overview:
- Sequencing controller for the folded 4-cell Euclidean key-equation array of the BCH decoder (GF(2^13), t=8).
- Accepts a syndrome codeword from the syndrome stage and streams it into the array on the first pass.
- Then closes the feedback loop and counts recirculation passes until all 2t iterations are done.
- Hands the error-locator stream to the Chien search with a valid/ready handshake and flags decoding failure.

Parameters:
- LOOP_LEN, 20, cycles for one trip around the array plus its feedback delay line; one pass.
- SEQ_LEN, 17, coefficient beats per polynomial stream (2t+1); must satisfy 1 <= SEQ_LEN <= LOOP_LEN.
- NUM_PASSES, 4, total passes per codeword (2t / cells = 16/4).
- CW, 5, cycle counter width; must satisfy 2^CW >= LOOP_LEN.

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous, active-low.
- syn_valid, in, 1, syndrome stage has a codeword ready to stream.
- syn_ready, out, 1, controller accepts a codeword.
- src_en, out, 1, upstream advances one coefficient per cycle while high.
- arr_start, out, 1, start marker into the array, and the array cycle-count enable.
- arr_feedback_sel, out, 1, 1 = external input path, 0 = loop feedback path.
- arr_stop, in, 1, array stop flag at the loop output (degree condition met).
- out_valid, out, 1, Lout/Uout beat valid for the Chien search.
- out_ready, in, 1, Chien search can take a full stream.
- out_fail, out, 1, decoding failure; valid while out_valid is high.
- done, out, 1, one-cycle pulse on the last cycle of a codeword.
- busy, out, 1, high in any state other than IDLE.
- pass_cnt, out, 3, current pass index, 0..NUM_PASSES.

Behaviour:
- Reset values:
  - State = IDLE.
  - syn_ready=1, arr_feedback_sel=1.
  - src_en, arr_start, out_valid, out_fail, done, busy = 0.
  - pass_cnt=0, cyc_cnt=0.
- All outputs are registered; reset may assert at any cycle and returns everything to the reset values immediately.
- IDLE:
  - syn_ready=1.
  - syn_valid & syn_ready at an edge -> LOAD, with cyc_cnt=0, pass_cnt=0.
- LOAD (LOOP_LEN cycles):
  - arr_feedback_sel=1.
  - src_en=1 for cyc_cnt 0..SEQ_LEN-1.
  - arr_start=1 at cyc_cnt 0 only.
  - At cyc_cnt=LOOP_LEN-1 -> ITER, with arr_feedback_sel=0, pass_cnt=1, cyc_cnt=0.
- ITER:
  - arr_feedback_sel=0.
  - cyc_cnt wraps at LOOP_LEN-1; pass_cnt increments on each wrap.
  - At the wrap where pass_cnt becomes NUM_PASSES:
    - out_ready=1 -> OUT.
    - otherwise -> HOLD.
  - out_fail is latched at that wrap as ~arr_stop.
- HOLD:
  - The loop keeps circulating; cells pass data through once stopped, and pass_cnt saturates at NUM_PASSES.
  - Leave only on a loop boundary (cyc_cnt=LOOP_LEN-1) with out_ready=1 -> OUT.
  - out_fail is re-latched at each boundary.
- OUT (LOOP_LEN cycles):
  - out_valid=1 for cyc_cnt 0..SEQ_LEN-1.
  - out_ready is not re-checked mid-stream.
  - done=1 at cyc_cnt=LOOP_LEN-1, then -> IDLE.
  - Exactly one bubble cycle before the next acceptance.
- syn_valid outside IDLE is ignored, with syn_ready=0; there is no queuing.
- Counters:
  - cyc_cnt is unsigned CW bits and is compared against LOOP_LEN-1; it never exceeds that value.
  - pass_cnt never exceeds NUM_PASSES.

Decomposition:
- Shared package bch_pkg:
  - constants T=8, M=13, NUM_CELLS=4, DEG_W=5.
  - Derived: SEQ_LEN=2*T+1, NUM_PASSES=2*T/NUM_CELLS.
  - State enum IDLE/LOAD/ITER/HOLD/OUT.
- One sub-module, euclid_pass_counter: cyc_cnt/pass_cnt with wrap and saturate, exposing a loop_end strobe.

Test Plan:
- Single codeword, out_ready=1, arr_stop=1. Accept at edge 0. Required:
  - arr_start high 1 cycle, src_en high 17 cycles, arr_feedback_sel falls after 20 cycles.
  - out_valid high cycles 80..96, done at cycle 99, out_fail=0.
- arr_stop=0 at the final pass boundary -> out_fail=1 throughout the out_valid window.
- out_ready low from cycle 70 to 105:
  - HOLD entered at 80.
  - OUT starts at the next loop boundary with out_ready high, at 120 (out_valid 120..136).
  - pass_cnt stays at 4.
- syn_valid held high continuously -> syn_ready high only in IDLE; back-to-back acceptances exactly 101 cycles apart.
- Reset asserted at cycle 45 mid-ITER -> all outputs at reset values asynchronously; the next syn_valid restarts a full sequence from LOAD.
- syn_valid pulsed during LOAD/ITER/OUT -> ignored, with no change to pass_cnt or timing.
